re_idct4_pipe: RTL and testbench

Pipelined 4-point inverse core transform for the reconstruction path. It is the consumer-side counterpart of the forward level-2 coefficient multiplier.
- Accepts one row/column of 4 dequantized coefficients per cycle.
- Applies the HEVC inverse 4-point DCT even/odd butterfly (constants 64/83/36), then rounding, shift and clip.
- Emits 4 residual samples per cycle with valid/ready flow control and 4x4 block framing.
- Used for both passes of the 2-D inverse transform; a per-row pass tag selects the shift.

---
 rtl/re_tq_pkg.sv | 30 +++
 rtl/re_rnd_shift_clip.sv | 39 +++
 rtl/re_idct4_pipe.sv | 150 +++++++++++++++
 tb/tb_re_idct4_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/re_tq_pkg.sv
// Shared constants and types for the reconstruction-path inverse transform.
// The optional inverse DST-VII path is enabled by defining RE_IDST4_EN.
package re_tq_pkg;

    // HEVC 4-point DCT basis constants
    localparam int unsigned C64 = 64;
    localparam int unsigned C83 = 83;
    localparam int unsigned C36 = 36;

    // HEVC 4-point DST-VII basis constants
    localparam int unsigned C29 = 29;
    localparam int unsigned C55 = 55;
    localparam int unsigned C74 = 74;
    localparam int unsigned C84 = 84;

    localparam int unsigned DefShift1 = 7;
    localparam int unsigned DefShift2 = 12;

    localparam int unsigned DefInW    = 16;
    localparam int unsigned DefOutW   = 16;
    // Growth of a coefficient through one weighted sum of basis constants
    localparam int unsigned ProdGrow  = 9;
    localparam int unsigned SumGrow   = 10;

    typedef struct packed {
        logic pass;
        logic dst;
    } row_tag_t;

endpackage

// File: rtl/re_rnd_shift_clip.sv
// Combinational round, arithmetic right shift and saturation of one transform sum.
// The shift (and its rounding offset) is picked per row by the pass tag.
module re_rnd_shift_clip
    import re_tq_pkg::*;
#(
    parameter int unsigned IN_W   = DefInW + SumGrow,
    parameter int unsigned OUT_W  = DefOutW,
    parameter int unsigned SHIFT1 = DefShift1,
    parameter int unsigned SHIFT2 = DefShift2
) (
    input  logic signed [IN_W-1:0]  sum_i,
    input  logic                    pass_i,
    output logic signed [OUT_W-1:0] res_o
);

    // One extra bit so the rounding add can never wrap
    localparam int unsigned W = IN_W + 1;

    localparam logic signed [W-1:0] Rnd1 = W'(2 ** (SHIFT1 - 1));
    localparam logic signed [W-1:0] Rnd2 = W'(2 ** (SHIFT2 - 1));
    localparam logic signed [W-1:0] MaxV = W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [W-1:0] MinV = ~MaxV;

    logic signed [W-1:0] rnd;
    logic signed [W-1:0] shifted;

    always_comb begin
        rnd     = W'(sum_i) + (pass_i ? Rnd2 : Rnd1);
        shifted = pass_i ? (rnd >>> SHIFT2) : (rnd >>> SHIFT1);
        if (shifted > MaxV) begin
            res_o = MaxV[OUT_W-1:0];
        end else if (shifted < MinV) begin
            res_o = MinV[OUT_W-1:0];
        end else begin
            res_o = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/re_idct4_pipe.sv
// Three-stage pipelined 4-point inverse DCT (even/odd butterfly) with flow control and
// 4x4 block row framing. Define RE_IDST4_EN to add the per-row inverse DST-VII path.
module re_idct4_pipe
    import re_tq_pkg::*;
#(
    parameter int unsigned IN_W   = DefInW,
    parameter int unsigned OUT_W  = DefOutW,
    parameter int unsigned SHIFT1 = DefShift1,
    parameter int unsigned SHIFT2 = DefShift2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_vld,
    output logic                    o_rdy,
    input  logic                    i_pass,
    input  logic                    i_dst,
    input  logic signed [IN_W-1:0]  i_c0,
    input  logic signed [IN_W-1:0]  i_c1,
    input  logic signed [IN_W-1:0]  i_c2,
    input  logic signed [IN_W-1:0]  i_c3,
    output logic                    o_vld,
    input  logic                    i_rdy,
    output logic signed [OUT_W-1:0] o_r0,
    output logic signed [OUT_W-1:0] o_r1,
    output logic signed [OUT_W-1:0] o_r2,
    output logic signed [OUT_W-1:0] o_r3,
    output logic [1:0]              o_row_idx,
    output logic                    o_blk_end
);

    localparam int unsigned PROD_W = IN_W + ProdGrow;
    localparam int unsigned SUM_W  = IN_W + SumGrow;

    // Constant multiply as a sum of shifted copies of x, one per set bit of k
    function automatic logic signed [PROD_W-1:0] cmul(input logic signed [IN_W-1:0] x,
                                                       input int unsigned k);
        logic signed [PROD_W-1:0] acc;
        acc = '0;
        for (int b = 0; b < 8; b++) begin
            if (k[b]) acc = acc + (PROD_W'(x) <<< b);
        end
        return acc;
    endfunction

    logic                     en;
    logic                     accept;
    logic                     vld1_q, vld2_q, vld3_q;
    row_tag_t                 tag_d, tag1_q;
    logic signed [PROD_W-1:0] p_d [4];
    logic signed [PROD_W-1:0] p_q [4];
    logic signed [SUM_W-1:0]  s [4];
    logic signed [OUT_W-1:0]  r2_d [4];
    logic signed [OUT_W-1:0]  r2_q [4];
    logic signed [OUT_W-1:0]  r3_q [4];
    logic [1:0]               row_q;

    assign en     = !vld3_q || i_rdy;
    assign o_rdy  = en;
    assign accept = i_vld && en;

    // S1: p_d[0..3] hold E0, E1, O0, O1 (or the four DST sums directly)
    always_comb begin
        tag_d.pass = i_pass;
        p_d[0] = cmul(i_c0, C64) + cmul(i_c2, C64);
        p_d[1] = cmul(i_c0, C64) - cmul(i_c2, C64);
        p_d[2] = cmul(i_c1, C83) + cmul(i_c3, C36);
        p_d[3] = cmul(i_c1, C36) - cmul(i_c3, C83);
`ifdef RE_IDST4_EN
        tag_d.dst = i_dst;
        if (i_dst) begin
            p_d[0] = cmul(i_c0, C29) + cmul(i_c1, C74) + cmul(i_c2, C84) + cmul(i_c3, C55);
            p_d[1] = cmul(i_c0, C55) + cmul(i_c1, C74) - cmul(i_c2, C29) - cmul(i_c3, C84);
            p_d[2] = cmul(i_c0, C74) - cmul(i_c2, C74) + cmul(i_c3, C74);
            p_d[3] = cmul(i_c0, C84) - cmul(i_c1, C74) + cmul(i_c2, C55) - cmul(i_c3, C29);
        end
`else
        tag_d.dst = 1'b0;
`endif
    end

`ifndef RE_IDST4_EN
    logic unused_dst;
    assign unused_dst = i_dst ^ tag1_q.dst;
`endif

    // S2 butterfly
    always_comb begin
        s[0] = SUM_W'(p_q[0]) + SUM_W'(p_q[2]);
        s[1] = SUM_W'(p_q[1]) + SUM_W'(p_q[3]);
        s[2] = SUM_W'(p_q[1]) - SUM_W'(p_q[3]);
        s[3] = SUM_W'(p_q[0]) - SUM_W'(p_q[2]);
`ifdef RE_IDST4_EN
        if (tag1_q.dst) begin
            for (int i = 0; i < 4; i++) s[i] = SUM_W'(p_q[i]);
        end
`endif
    end

    for (genvar g = 0; g < 4; g++) begin : g_rsc
        re_rnd_shift_clip #(
            .IN_W  (SUM_W),
            .OUT_W (OUT_W),
            .SHIFT1(SHIFT1),
            .SHIFT2(SHIFT2)
        ) u_rsc (
            .sum_i (s[g]),
            .pass_i(tag1_q.pass),
            .res_o (r2_d[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld1_q <= 1'b0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            tag1_q <= '0;
            for (int i = 0; i < 4; i++) begin
                p_q[i]  <= '0;
                r2_q[i] <= '0;
                r3_q[i] <= '0;
            end
        end else if (en) begin
            vld1_q <= accept;
            tag1_q <= tag_d;
            p_q    <= p_d;
            vld2_q <= vld1_q;
            r2_q   <= r2_d;
            vld3_q <= vld2_q;
            r3_q   <= r2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q <= 2'd0;
        end else if (vld3_q && i_rdy) begin
            row_q <= row_q + 2'd1;
        end
    end

    assign o_vld     = vld3_q;
    assign o_r0      = r3_q[0];
    assign o_r1      = r3_q[1];
    assign o_r2      = r3_q[2];
    assign o_r3      = r3_q[3];
    assign o_row_idx = row_q;
    assign o_blk_end = vld3_q && (row_q == 2'd3);

endmodule

// File: tb/tb_re_idct4_pipe.sv
// Self-checking bench for re_idct4_pipe: directed cases plus random traffic with
// random backpressure, scored against a matrix-form reference model.
module tb_re_idct4_pipe;

    localparam int IN_W  = 16;
    localparam int OUT_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic i_vld, o_rdy, i_pass, i_dst, o_vld, i_rdy, o_blk_end;
    logic signed [IN_W-1:0]  c0, c1, c2, c3;
    logic signed [OUT_W-1:0] o_r0, o_r1, o_r2, o_r3;
    logic [1:0]              o_row_idx;

    always #5 clk = ~clk;

    re_idct4_pipe u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_vld    (i_vld),
        .o_rdy    (o_rdy),
        .i_pass   (i_pass),
        .i_dst    (i_dst),
        .i_c0     (c0),
        .i_c1     (c1),
        .i_c2     (c2),
        .i_c3     (c3),
        .o_vld    (o_vld),
        .i_rdy    (i_rdy),
        .o_r0     (o_r0),
        .o_r1     (o_r1),
        .o_r2     (o_r2),
        .o_r3     (o_r3),
        .o_row_idx(o_row_idx),
        .o_blk_end(o_blk_end)
    );

    int n_checks = 0;
    int n_errors = 0;
    int exp_idx  = 0;
    logic signed [OUT_W-1:0] exp_q [$];
    logic                    use_dir = 1'b0;
    logic signed [OUT_W-1:0] dir_e [4];
    logic                    acc_b;

    // Inverse transform matrices: residual k = sum_j m[k][j] * c_j
    int dct_m [4][4] = '{'{64, 83, 64, 36}, '{64, 36, -64, -83},
                         '{64, -36, -64, 83}, '{64, -83, 64, -36}};
    int dst_m [4][4] = '{'{29, 74, 84, 55}, '{55, 74, -29, -84},
                         '{74, 0, -74, 74}, '{84, -74, 55, -29}};

    task automatic check(input string tag, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic logic signed [OUT_W-1:0] ref_res(input int k, input logic pass,
                                                         input logic dst);
        int     cv [4];
        longint acc;
        int     sh;
        logic   use_dst;
        use_dst = 1'b0;
`ifdef RE_IDST4_EN
        use_dst = dst;
`endif
        cv[0] = c0; cv[1] = c1; cv[2] = c2; cv[3] = c3;
        acc = 0;
        for (int j = 0; j < 4; j++) begin
            acc += longint'(use_dst ? dst_m[k][j] : dct_m[k][j]) * longint'(cv[j]);
        end
        sh  = pass ? 12 : 7;
        acc = (acc + (longint'(1) <<< (sh - 1))) >>> sh;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[OUT_W-1:0];
    endfunction

    function automatic logic signed [IN_W-1:0] rnd_coef();
        if ($urandom % 4 == 0) return IN_W'($urandom);
        return IN_W'($urandom_range(0, 1023)) - 16'sd512;
    endfunction

    // Called just after inputs are driven at a negedge; ends at the next negedge.
    task automatic tick(output logic accepted);
        #1;
        if (o_vld && i_rdy) begin
            if (exp_q.size() < 4) begin
                check("spurious_row", 1, 0);
            end else begin
                check("r0", o_r0, exp_q.pop_front());
                check("r1", o_r1, exp_q.pop_front());
                check("r2", o_r2, exp_q.pop_front());
                check("r3", o_r3, exp_q.pop_front());
                check("row_idx", o_row_idx, exp_idx);
                check("blk_end", o_blk_end, exp_idx == 3);
                exp_idx = (exp_idx + 1) % 4;
            end
        end else if (!o_vld) begin
            check("blk_end_idle", o_blk_end, 0);
        end
        accepted = i_vld && o_rdy;
        if (accepted) begin
            for (int k = 0; k < 4; k++) exp_q.push_back(use_dir ? dir_e[k] :
                                                        ref_res(k, i_pass, i_dst));
        end
        @(negedge clk);
    endtask

    task automatic send_dir(input int a0, input int a1, input int a2, input int a3,
                            input logic pass, input logic dst,
                            input int e0, input int e1, input int e2, input int e3);
        logic got;
        got = 1'b0;
        c0 = IN_W'(a0); c1 = IN_W'(a1); c2 = IN_W'(a2); c3 = IN_W'(a3);
        i_pass = pass; i_dst = dst; i_vld = 1'b1;
        dir_e[0] = OUT_W'(e0); dir_e[1] = OUT_W'(e1);
        dir_e[2] = OUT_W'(e2); dir_e[3] = OUT_W'(e3);
        use_dir = 1'b1;
        for (int n = 0; n < 20 && !got; n++) tick(got);
        if (!got) check("accept_timeout", 0, 1);
        use_dir = 1'b0;
        i_vld   = 1'b0;
    endtask

    task automatic drain();
        logic a;
        i_vld = 1'b0;
        i_rdy = 1'b1;
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) tick(a);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        i_vld = 1'b0; i_rdy = 1'b1; i_pass = 1'b0; i_dst = 1'b0;
        c0 = '0; c1 = '0; c2 = '0; c3 = '0;
        repeat (2) @(negedge clk);
        check("rst_o_vld", o_vld, 0);
        check("rst_o_rdy", o_rdy, 1);
        check("rst_o_r0", o_r0, 0);
        check("rst_o_r1", o_r1, 0);
        check("rst_o_r2", o_r2, 0);
        check("rst_o_r3", o_r3, 0);
        check("rst_row_idx", o_row_idx, 0);
        check("rst_blk_end", o_blk_end, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // DC row with latency check, then the remaining directed rows of one block
        send_dir(64, 0, 0, 0, 1'b0, 1'b0, 32, 32, 32, 32);
        check("lat_cycle1", o_vld, 0);
        tick(acc_b);
        check("lat_cycle2", o_vld, 0);
        tick(acc_b);
        check("lat_cycle3", o_vld, 1);
        send_dir(0, 100, 0, 0, 1'b0, 1'b0, 65, 28, -28, -65);
        send_dir(32767, 32767, 32767, 32767, 1'b0, 1'b0, 32767, -12032, 12032, 2304);
        send_dir(4096, 0, 0, 0, 1'b1, 1'b0, 64, 64, 64, 64);
        drain();

        // Four back-to-back rows with two stall cycles mid-stream
        begin
            int sent;
            sent = 0;
            for (int n = 0; n < 14; n++) begin
                i_rdy = !(n == 3 || n == 4);
                if (sent < 4) begin
                    if (n == 0 || acc_b) begin
                        c0 = rnd_coef(); c1 = rnd_coef(); c2 = rnd_coef(); c3 = rnd_coef();
                        i_pass = 1'($urandom);
                    end
                    i_vld = 1'b1;
                end else begin
                    i_vld = 1'b0;
                end
                tick(acc_b);
                if (acc_b) sent++;
            end
            check("stall_rows_sent", sent, 4);
        end
        drain();

        // Random traffic with random backpressure
        for (int n = 0; n < 600; n++) begin
            i_vld  = ($urandom % 4) != 0;
            i_rdy  = ($urandom % 3) != 0;
            i_pass = 1'($urandom);
            i_dst  = 1'($urandom);
            c0 = rnd_coef(); c1 = rnd_coef(); c2 = rnd_coef(); c3 = rnd_coef();
            tick(acc_b);
        end
        drain();

        // Reset asserted mid-block with rows in flight
        i_rdy = 1'b1;
        i_dst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            i_vld = 1'b1;
            c0 = rnd_coef(); c1 = rnd_coef(); c2 = rnd_coef(); c3 = rnd_coef();
            tick(acc_b);
        end
        i_vld = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_o_vld", o_vld, 0);
        check("midrst_row_idx", o_row_idx, 0);
        check("midrst_o_rdy", o_rdy, 1);
        exp_q.delete();
        exp_idx = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_dir(64, 0, 0, 0, 1'b0, 1'b0, 32, 32, 32, 32);
        drain();

`ifdef RE_IDST4_EN
        send_dir(128, 0, 0, 0, 1'b0, 1'b1, 29, 55, 74, 84);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
